fgcap_freq_counter: RTL and testbench



---
 rtl/fgcap_pkg.sv | 18 +
 rtl/fgcap_sync_edge.sv | 34 +++
 rtl/fgcap_freq_counter.sv | 128 ++++++++++++
 tb/tb_fgcap_freq_counter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fgcap_pkg.sv
// fgcap_pkg: shared types and default widths for the floating-gate capacitor
// oscillator frequency counter.
//   state_t         - measurement FSM states
//   *_DEF constants - default parameter values for the counter and its sync stage
package fgcap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int GATE_W_DEF      = 24;
    localparam int CNT_W_DEF       = 16;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/fgcap_sync_edge.sv
// fgcap_sync_edge: multi-flop synchronizer followed by a rising-edge detector.
//   clk      in  - sampling clock
//   rst      in  - synchronous active-high reset, clears all flops
//   async_in in  - asynchronous input (oscillator pin)
//   edge_p   out - one-clock pulse per synchronized rising edge
module fgcap_sync_edge
    import fgcap_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic edge_p
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // High only in the first cycle the synchronized level is seen high, so a
    // toggling input yields at most one pulse every two clocks.
    assign edge_p = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/fgcap_freq_counter.sv
// fgcap_freq_counter: counts rising edges of an asynchronous oscillator over a
// programmable window of wb_clk_i cycles and exposes the result in parallel and
// through a 1-bit shift readout.
//   wb_clk_i    in  - block clock
//   wb_rst_i    in  - synchronous active-high reset
//   osc_in      in  - asynchronous oscillator input
//   gate_cycles in  - window length in clocks, captured when the run arms
//   start       in  - one-cycle request to begin a measurement (ignored when busy)
//   busy        out - high while arming and during the gate window
//   done        out - one-cycle pulse when a result is committed
//   count       out - last committed edge count (saturating)
//   overflow    out - last measurement saturated
//   rd_load     in  - load {overflow, count} into the readout register
//   rd_shift    in  - shift the readout register left, filling 0
//   sdo         out - readout register MSB
module fgcap_freq_counter
    import fgcap_pkg::*;
#(
    parameter int GATE_W      = GATE_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              osc_in,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    input  logic              rd_load,
    input  logic              rd_shift,
    output logic              sdo
);

    state_t            state;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  acc;
    logic              sat;
    logic [CNT_W-1:0]  acc_nxt;
    logic              sat_nxt;
    logic              edge_p;
    logic [CNT_W:0]    rd_sr;

    // Returns {sat, acc} after one gate cycle: at full scale the accumulator
    // holds and the saturation flag sticks instead of wrapping.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] a,
                                               input logic             s,
                                               input logic             e);
        logic [CNT_W:0] r;
        r = {s, a};
        if (e) begin
            if (a == {CNT_W{1'b1}}) r = {1'b1, a};
            else                    r = {s, a + 1'b1};
        end
        return r;
    endfunction

    fgcap_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .async_in (osc_in),
        .edge_p   (edge_p)
    );

    always_comb begin
        {sat_nxt, acc_nxt} = sat_inc(acc, sat, edge_p);
    end

    // Control and committed result. The result is written on the edge that
    // enters DONE so the new count is visible together with the done pulse.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= ST_IDLE;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start) state <= ST_ARM;
                ST_ARM: begin
                    if (gate_cycles == '0) begin
                        count    <= '0;
                        overflow <= 1'b0;
                        state    <= ST_DONE;
                    end else begin
                        state <= ST_GATE;
                    end
                end
                ST_GATE: begin
                    if (gate_cnt == GATE_W'(1)) begin
                        count    <= acc_nxt;
                        overflow <= sat_nxt;
                        state    <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Window datapath; only meaningful while ARM/GATE, so it carries no reset.
    always_ff @(posedge wb_clk_i) begin
        if (state == ST_ARM) begin
            gate_cnt <= gate_cycles;
            acc      <= '0;
            sat      <= 1'b0;
        end else if (state == ST_GATE) begin
            gate_cnt <= gate_cnt - 1'b1;
            acc      <= acc_nxt;
            sat      <= sat_nxt;
        end
    end

    // Readout shifter; load has priority over shift.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)      rd_sr <= '0;
        else if (rd_load)  rd_sr <= {overflow, count};
        else if (rd_shift) rd_sr <= {rd_sr[CNT_W-1:0], 1'b0};
    end

    assign busy = (state == ST_ARM) || (state == ST_GATE);
    assign done = (state == ST_DONE);
    assign sdo  = rd_sr[CNT_W];

endmodule

// File: tb/tb_fgcap_freq_counter.sv
module tb_fgcap_freq_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        osc = 1'b0;
    logic        start = 1'b0;
    logic        rd_load = 1'b0;
    logic        rd_shift = 1'b0;
    logic [23:0] gate_cycles = '0;

    logic        busy, done, overflow, sdo;
    logic [15:0] count;
    logic        busy8, done8, ovf8, sdo8;
    logic [7:0]  count8;

    int checks = 0;
    int failures = 0;
    int osc_period = 0;
    int ph = 0;

    always #5 clk = ~clk;

    // Main instance (16-bit count) and a narrow instance for reachable saturation.
    fgcap_freq_counter #(.GATE_W(24), .CNT_W(16), .SYNC_STAGES(2)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .osc_in(osc), .gate_cycles(gate_cycles),
        .start(start), .busy(busy), .done(done), .count(count), .overflow(overflow),
        .rd_load(rd_load), .rd_shift(rd_shift), .sdo(sdo)
    );

    fgcap_freq_counter #(.GATE_W(24), .CNT_W(8), .SYNC_STAGES(2)) dut8 (
        .wb_clk_i(clk), .wb_rst_i(rst), .osc_in(osc), .gate_cycles(gate_cycles),
        .start(start), .busy(busy8), .done(done8), .count(count8), .overflow(ovf8),
        .rd_load(rd_load), .rd_shift(rd_shift), .sdo(sdo8)
    );

    // Oscillator stepped on the falling edge, period in clocks (0 = held low).
    always @(negedge clk) begin
        if (osc_period == 0) begin
            ph  = 0;
            osc = 1'b0;
        end else begin
            ph  = (ph + 1) % osc_period;
            osc = (ph < osc_period / 2);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        int period;
        int n;
        int exp16;
        int exp8;
        int ovf8;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        int  busy_cnt;
        int  done_k;
        bit  got;
        osc_period  = v.period;
        gate_cycles = 24'(v.n);
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        busy_cnt = 0;
        done_k   = -1;
        got      = 1'b0;
        for (int k = 0; k < v.n + 20 && !got; k++) begin
            if (done) begin
                got    = 1'b1;
                done_k = k;
                check("done_busy_low", 32'(busy), 32'd0);
                check("done8_align", 32'(done8), 32'd1);
                check("count", 32'(count), 32'(v.exp16));
                check("overflow", 32'(overflow), 32'd0);
                check("count8", 32'(count8), 32'(v.exp8));
                check("overflow8", 32'(ovf8), 32'(v.ovf8));
            end else begin
                if (busy) busy_cnt++;
                @(negedge clk);
            end
        end
        check("done_seen", 32'(got), 32'd1);
        check("done_cycle", 32'(done_k), 32'(v.n + 1));
        check("busy_cycles", 32'(busy_cnt), 32'(v.n + 1));
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] rd_exp;
        int          viol;
        int          npulse;
        int          cnt_at_done;

        vecs[0] = '{period: 10, n: 1000, exp16: 100,  exp8: 100, ovf8: 0};
        vecs[1] = '{period: 0,  n: 0,    exp16: 0,    exp8: 0,   ovf8: 0};
        vecs[2] = '{period: 0,  n: 50,   exp16: 0,    exp8: 0,   ovf8: 0};
        vecs[3] = '{period: 2,  n: 1000, exp16: 500,  exp8: 255, ovf8: 1};
        vecs[4] = '{period: 10, n: 1000, exp16: 100,  exp8: 100, ovf8: 0};
        vecs[5] = '{period: 2,  n: 9320, exp16: 4660, exp8: 255, ovf8: 1};

        // Reset with the oscillator toggling.
        osc_period = 2;
        repeat (6) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_sdo", 32'(sdo), 32'd0);
        rst  = 1'b0;
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || done) viol++;
        end
        check("post_rst_idle", 32'(viol), 32'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Readout of count=0x1234, overflow=0.
        rd_exp = 17'h01234;
        @(negedge clk);
        rd_load = 1'b1;
        @(negedge clk);
        rd_load = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            check("sdo_seq", 32'(sdo), 32'(rd_exp[16-i]));
            rd_shift = (i < 16);
            @(negedge clk);
        end
        rd_shift = 1'b0;
        // Load and shift together must load; four further shifts then expose bit 12.
        rd_load  = 1'b1;
        rd_shift = 1'b1;
        @(negedge clk);
        rd_load = 1'b0;
        check("ld_sh_msb", 32'(sdo), 32'd0);
        repeat (4) @(negedge clk);
        rd_shift = 1'b0;
        check("ld_sh_bit12", 32'(sdo), 32'd1);

        // start during GATE is ignored and not queued.
        osc_period  = 10;
        gate_cycles = 24'd100;
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        npulse      = 0;
        cnt_at_done = -1;
        repeat (200) begin
            if (done) begin
                npulse++;
                cnt_at_done = int'(count);
            end
            @(negedge clk);
        end
        check("ignored_start_pulses", 32'(npulse), 32'd1);
        check("ignored_start_count", 32'(cnt_at_done), 32'd10);
        check("ignored_start_idle", 32'(busy), 32'd0);

        // Reset in the middle of a window.
        gate_cycles = 24'd1000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        check("mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        repeat (5) @(negedge clk);
        check("mid_rst_stay_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
